// File: rtl/mux_n_reg_pkg.sv
// ---------------------------------------------------------------------------
// mux_n_reg_pkg
// Shared pipeline package: default data width, the pipeline bubble value
// loaded into stage registers on reset/flush, and the select-width helper.
// ---------------------------------------------------------------------------
package mux_n_reg_pkg;

    localparam int unsigned DATA_W = 32;

    // Value a pipeline register carries when it holds a bubble.
    localparam logic [DATA_W-1:0] PIPE_BUBBLE = '0;

    // ceil(log2(n)) for n >= 2: smallest w with 2**w >= n.
    function automatic int unsigned sel_width(input int unsigned n);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/mux_n_reg_mux.sv
// ---------------------------------------------------------------------------
// MUX_N
// Purely combinational N-input, bits-wide selector.
//   DataIn   : INPUTS*bits packed inputs, input k at [k*bits +: bits]
//   Signal   : select index
//   sel_data : selected input, or input 0 when Signal >= INPUTS
//   sel_err  : 1 when Signal >= INPUTS
// ---------------------------------------------------------------------------
module MUX_N
    import mux_n_reg_pkg::*;
#(
    parameter int unsigned bits   = DATA_W,
    parameter int unsigned INPUTS = 4,
    localparam int unsigned SELW  = sel_width(INPUTS)
) (
    input  logic [INPUTS*bits-1:0] DataIn,
    input  logic [SELW-1:0]        Signal,
    output logic [bits-1:0]        sel_data,
    output logic                   sel_err
);

    // Error is cleared only by matching a legal index, so no explicit
    // range compare is needed and out-of-range selects resolve to input 0.
    always_comb begin
        sel_data = DataIn[0 +: bits];
        sel_err  = 1'b1;
        for (int unsigned k = 0; k < INPUTS; k++) begin
            if (Signal == SELW'(k)) begin
                sel_data = DataIn[k*bits +: bits];
                sel_err  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_n_reg.sv
// ---------------------------------------------------------------------------
// mux_n_reg
// N-input selector with a registered output stage, stall/flush control and
// a valid bit travelling with the data. Priority: rst > Flush > Stall > load.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   DataIn   : INPUTS*bits packed data inputs
//   Signal   : select index (SELW bits)
//   ValidIn  : selected data meaningful this cycle
//   Stall    : hold all registered outputs
//   Flush    : load a bubble (overrides Stall)
//   DataOut  : registered selected data
//   ValidOut : registered valid
//   SelErr   : registered flag, last loaded select was out of range
// ---------------------------------------------------------------------------
module mux_n_reg
    import mux_n_reg_pkg::*;
#(
    parameter int unsigned     bits      = DATA_W,
    parameter int unsigned     INPUTS    = 4,
    parameter int unsigned     SELW      = 2,
    parameter logic [bits-1:0] RESET_VAL = bits'(PIPE_BUBBLE)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INPUTS*bits-1:0] DataIn,
    input  logic [SELW-1:0]        Signal,
    input  logic                   ValidIn,
    input  logic                   Stall,
    input  logic                   Flush,
    output logic [bits-1:0]        DataOut,
    output logic                   ValidOut,
    output logic                   SelErr
);

    if (SELW != sel_width(INPUTS)) begin : g_bad_selw
        $error("mux_n_reg: SELW must equal ceil(log2(INPUTS))");
    end
    if (INPUTS < 2 || INPUTS > 8) begin : g_bad_inputs
        $error("mux_n_reg: INPUTS must be in 2..8");
    end
    if (bits < 1) begin : g_bad_bits
        $error("mux_n_reg: bits must be >= 1");
    end

    logic [bits-1:0] sel_data;
    logic            sel_err;

    MUX_N #(
        .bits   (bits),
        .INPUTS (INPUTS)
    ) u_mux (
        .DataIn   (DataIn),
        .Signal   (Signal),
        .sel_data (sel_data),
        .sel_err  (sel_err)
    );

    logic [bits-1:0] data_q, data_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        err_d   = err_q;
        if (Flush) begin
            data_d  = RESET_VAL;
            valid_d = 1'b0;
            err_d   = 1'b0;
        end else if (!Stall) begin
            // Data is captured even when ValidIn is low; ValidOut qualifies it.
            data_d  = sel_data;
            valid_d = ValidIn;
            err_d   = sel_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= RESET_VAL;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign DataOut  = data_q;
    assign ValidOut = valid_q;
    assign SelErr   = err_q;

endmodule

// File: tb/tb_mux_n_reg.sv
module tb_mux_n_reg;

    logic        clk;
    logic        rst;
    logic        Flush;
    logic        Stall;
    logic        ValidIn;
    logic [1:0]  Signal;
    logic [31:0] din [4];

    logic [127:0] din4;
    logic [95:0]  din3;
    assign din4 = {din[3], din[2], din[1], din[0]};
    assign din3 = {din[2], din[1], din[0]};

    logic [31:0] d4_data, d3_data;
    logic        d4_valid, d3_valid, d4_err, d3_err;

    mux_n_reg #(
        .bits      (32),
        .INPUTS    (4),
        .SELW      (2),
        .RESET_VAL (32'h0)
    ) dut4 (
        .clk      (clk),
        .rst      (rst),
        .DataIn   (din4),
        .Signal   (Signal),
        .ValidIn  (ValidIn),
        .Stall    (Stall),
        .Flush    (Flush),
        .DataOut  (d4_data),
        .ValidOut (d4_valid),
        .SelErr   (d4_err)
    );

    mux_n_reg #(
        .bits      (32),
        .INPUTS    (3),
        .SELW      (2),
        .RESET_VAL (32'h0)
    ) dut3 (
        .clk      (clk),
        .rst      (rst),
        .DataIn   (din3),
        .Signal   (Signal),
        .ValidIn  (ValidIn),
        .Stall    (Stall),
        .Flush    (Flush),
        .DataOut  (d3_data),
        .ValidOut (d3_valid),
        .SelErr   (d3_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int checks = 0;
    int errors = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Reference model: stage contents for a mux with n inputs.
    logic [31:0] m4_d = '0, m3_d = '0;
    logic        m4_v = 1'b0, m3_v = 1'b0, m4_e = 1'b0, m3_e = 1'b0;

    task automatic model_upd(input int n, inout logic [31:0] md, inout logic mv, inout logic me);
        if (rst || Flush) begin
            md = 32'h0;
            mv = 1'b0;
            me = 1'b0;
        end else if (!Stall) begin
            if (int'(Signal) < n) begin
                md = din[Signal];
                me = 1'b0;
            end else begin
                md = din[0];
                me = 1'b1;
            end
            mv = ValidIn;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_upd(4, m4_d, m4_v, m4_e);
        model_upd(3, m3_d, m3_v, m3_e);
        #1;
        check32("m4_data", d4_data, m4_d);
        check1("m4_valid", d4_valid, m4_v);
        check1("m4_err", d4_err, m4_e);
        check32("m3_data", d3_data, m3_d);
        check1("m3_valid", d3_valid, m3_v);
        check1("m3_err", d3_err, m3_e);
    endtask

    typedef struct packed {
        logic             rst;
        logic             flush;
        logic             stall;
        logic             vin;
        logic [1:0]       sig;
        logic [3:0][31:0] d;
        logic [31:0]      e_data;
        logic             e_valid;
        logic             e_err;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic f, input logic s, input logic v,
                                input logic [1:0] sg,
                                input logic [31:0] d3, input logic [31:0] d2,
                                input logic [31:0] d1, input logic [31:0] d0,
                                input logic [31:0] ed, input logic ev, input logic ee);
        vec_t t;
        t.rst = r; t.flush = f; t.stall = s; t.vin = v; t.sig = sg;
        t.d[3] = d3; t.d[2] = d2; t.d[1] = d1; t.d[0] = d0;
        t.e_data = ed; t.e_valid = ev; t.e_err = ee;
        return t;
    endfunction

    localparam int NV = 21;
    vec_t vecs [NV];

    initial begin
        // Expected values are the dut4 outputs right after the row's edge.
        vecs[0]  = mk(1,0,0,1, 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 0, 0);
        vecs[1]  = mk(1,0,0,1, 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 0, 0);
        vecs[2]  = mk(0,0,0,1, 2'd0, 32'h10000003, 32'h10000002, 32'h10000001, 32'h10000000, 32'h10000000, 1, 0);
        vecs[3]  = mk(0,0,0,1, 2'd1, 32'h10000003, 32'h10000002, 32'h10000001, 32'h10000000, 32'h10000001, 1, 0);
        vecs[4]  = mk(0,0,0,1, 2'd2, 32'h10000003, 32'h10000002, 32'h10000001, 32'h10000000, 32'h10000002, 1, 0);
        vecs[5]  = mk(0,0,0,1, 2'd3, 32'h10000003, 32'h10000002, 32'h10000001, 32'h10000000, 32'h10000003, 1, 0);
        vecs[6]  = mk(0,0,0,0, 2'd1, 32'h10000003, 32'h10000002, 32'h00001234, 32'h10000000, 32'h00001234, 0, 0);
        vecs[7]  = mk(0,0,0,1, 2'd2, 32'h10000003, 32'hDEADBEEF, 32'h10000001, 32'h10000000, 32'hDEADBEEF, 1, 0);
        vecs[8]  = mk(0,0,1,0, 2'd0, 32'h55555558, 32'h55555557, 32'h55555556, 32'h55555555, 32'hDEADBEEF, 1, 0);
        vecs[9]  = mk(0,0,1,1, 2'd1, 32'h55555558, 32'h55555557, 32'h55555556, 32'h55555555, 32'hDEADBEEF, 1, 0);
        vecs[10] = mk(0,0,1,0, 2'd3, 32'h55555558, 32'h55555557, 32'h55555556, 32'h55555555, 32'hDEADBEEF, 1, 0);
        vecs[11] = mk(0,0,0,1, 2'd1, 32'h55555558, 32'h55555557, 32'h55555556, 32'h55555555, 32'h55555556, 1, 0);
        vecs[12] = mk(0,1,1,1, 2'd0, 32'h55555558, 32'h55555557, 32'h55555556, 32'h55555555, 32'h0, 0, 0);
        vecs[13] = mk(0,0,1,1, 2'd3, 32'h55555558, 32'h55555557, 32'h55555556, 32'h55555555, 32'h0, 0, 0);
        vecs[14] = mk(0,0,1,1, 2'd2, 32'h55555558, 32'h55555557, 32'h55555556, 32'h55555555, 32'h0, 0, 0);
        vecs[15] = mk(0,0,0,1, 2'd3, 32'h77777777, 32'h55555557, 32'h55555556, 32'h55555555, 32'h77777777, 1, 0);
        vecs[16] = mk(0,1,0,1, 2'd3, 32'h77777777, 32'h55555557, 32'h55555556, 32'h55555555, 32'h0, 0, 0);
        vecs[17] = mk(0,0,0,1, 2'd0, 32'h77777777, 32'h55555557, 32'h55555556, 32'hABCDEF01, 32'hABCDEF01, 1, 0);
        vecs[18] = mk(1,0,0,1, 2'd0, 32'h77777777, 32'h55555557, 32'h55555556, 32'hABCDEF01, 32'h0, 0, 0);
        vecs[19] = mk(1,0,1,1, 2'd0, 32'h77777777, 32'h55555557, 32'h55555556, 32'hABCDEF01, 32'h0, 0, 0);
        vecs[20] = mk(0,0,0,1, 2'd2, 32'h77777777, 32'hCAFEF00D, 32'h55555556, 32'hABCDEF01, 32'hCAFEF00D, 1, 0);

        rst = 1'b1; Flush = 1'b0; Stall = 1'b0; ValidIn = 1'b0; Signal = 2'd0;
        for (int k = 0; k < 4; k++) din[k] = 32'hFFFFFFFF;

        // Table-driven directed vectors against dut4.
        for (int i = 0; i < NV; i++) begin
            rst = vecs[i].rst; Flush = vecs[i].flush; Stall = vecs[i].stall;
            ValidIn = vecs[i].vin; Signal = vecs[i].sig;
            for (int k = 0; k < 4; k++) din[k] = vecs[i].d[k];
            tick();
            check32($sformatf("vec%0d_data", i), d4_data, vecs[i].e_data);
            check1($sformatf("vec%0d_valid", i), d4_valid, vecs[i].e_valid);
            check1($sformatf("vec%0d_err", i), d4_err, vecs[i].e_err);
        end

        // Out-of-range select on the 3-input instance.
        rst = 1'b0; Flush = 1'b0; Stall = 1'b0; ValidIn = 1'b1;
        din[0] = 32'hA5A5A5A5; din[1] = 32'h11111111; din[2] = 32'h22222222; din[3] = 32'h33333333;
        Signal = 2'd3;
        tick();
        check32("oor_data", d3_data, 32'hA5A5A5A5);
        check1("oor_err", d3_err, 1'b1);
        check1("oor_valid", d3_valid, 1'b1);
        check1("oor_in_range4", d4_err, 1'b0);
        // Stall keeps the error flag even when the select becomes legal.
        Stall = 1'b1; Signal = 2'd1;
        tick();
        check1("oor_stall_err", d3_err, 1'b1);
        check32("oor_stall_data", d3_data, 32'hA5A5A5A5);
        // Next legal load clears it.
        Stall = 1'b0; Signal = 2'd2; din[2] = 32'h0BADF00D;
        tick();
        check1("oor_clear_err", d3_err, 1'b0);
        check32("oor_clear_data", d3_data, 32'h0BADF00D);

        // Randomized stimulus against the model.
        for (int n = 0; n < 400; n++) begin
            rst     = ($urandom_range(0, 49) == 0);
            Flush   = ($urandom_range(0, 9) == 0);
            Stall   = ($urandom_range(0, 3) == 0);
            ValidIn = 1'($urandom_range(0, 1));
            Signal  = 2'($urandom_range(0, 3));
            for (int k = 0; k < 4; k++) din[k] = $urandom;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
